// File: rtl/kanagawa_callback_responder.sv
// -----------------------------------------------------------------------------
// kanagawa_callback_responder
//
// Hardware servicer for an exported-class "add" callback. Argument tuples are
// popped from the class's show-ahead callback FIFO (cb_empty_in / cb_rden_out /
// cb_a_in / cb_b_in). The sum a+b (carry dropped) goes through a LATENCY-stage
// pipeline into an OUT_DEPTH-entry result FIFO. That FIFO is drained on the
// class's ready/valid result port.
//
// Flow control is credit based. A request is popped only when the count of
// in-flight plus buffered results is below OUT_DEPTH. This means the pipeline
// never has to stall and the result buffer can never overflow.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   cb_empty_in                request FIFO empty
//   cb_a_in, cb_b_in           operands, valid while !cb_empty_in
//   cb_rden_out                pop request FIFO (combinational, from registers
//                              and cb_empty_in only)
//   res_rdy_in                 consumer can take a result
//   res_valid_out              res_result_out holds a result
//   res_result_out             (a+b) mod 2^WIDTH
//   busy_out                   any request in pipeline or buffer
//   stall_rate_supported_out   stall injection compiled in
//   stall_rate_valid_in        load stall_rate_in
//   stall_rate_in              stall rate 0..7 (0 = never stall)
//
// Configuration macro
//   KANAGAWA_CALLBACK_RESPONDER_STALL_EN
//     When defined, an LFSR-driven stall throttles the pop rate.
//     When undefined, the stall inputs are ignored.
// -----------------------------------------------------------------------------
module kanagawa_callback_responder #(
  parameter int WIDTH     = 32,
  parameter int LATENCY   = 2,
  parameter int OUT_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cb_empty_in,
  input  logic [WIDTH-1:0] cb_a_in,
  input  logic [WIDTH-1:0] cb_b_in,
  output logic             cb_rden_out,
  input  logic             res_rdy_in,
  output logic             res_valid_out,
  output logic [WIDTH-1:0] res_result_out,
  output logic             busy_out,
  output logic             stall_rate_supported_out,
  input  logic             stall_rate_valid_in,
  input  logic [2:0]       stall_rate_in
);

  localparam int CNT_W = $clog2(OUT_DEPTH + 1);
  localparam int PTR_W = $clog2(OUT_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(OUT_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR_C = PTR_W'(OUT_DEPTH - 1);

  // Pointer increment with explicit wrap, so OUT_DEPTH need not be 2^n.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] n;
    if (p == LAST_PTR_C) begin
      n = PTR_W'(0);
    end else begin
      n = p + PTR_W'(1);
    end
    return n;
  endfunction

  logic             stall_s;
  logic             pop_s;
  logic             xfer_s;
  logic             wr_s;

  logic [WIDTH-1:0] sum_q [LATENCY];
  logic [WIDTH-1:0] sum_d [LATENCY];
  logic [LATENCY-1:0] vld_q, vld_d;

  logic [WIDTH-1:0] mem_q [OUT_DEPTH];
  logic [WIDTH-1:0] mem_d [OUT_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] buf_cnt_q, buf_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_result_q, res_result_d;

  // Credit check uses only registered count, so res_rdy_in never reaches rden.
  assign pop_s  = !rst && !cb_empty_in && (cnt_q < DEPTH_C) && !stall_s;
  assign xfer_s = res_valid_q && res_rdy_in;
  assign wr_s   = vld_q[LATENCY-1];

  assign cb_rden_out    = pop_s;
  assign res_valid_out  = res_valid_q;
  assign res_result_out = res_result_q;
  assign busy_out       = busy_q;

`ifdef KANAGAWA_CALLBACK_RESPONDER_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic [2:0]  rate_q, rate_d;

  // Next LFSR state (x^16+x^14+x^13+x^11+1, Fibonacci) and stall-rate load.
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    if (stall_rate_valid_in) begin
      rate_d = stall_rate_in;
    end else begin
      rate_d = rate_q;
    end
  end

  // LFSR and stall-rate registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= 16'hACE1;
      rate_q <= 3'd0;
    end else begin
      lfsr_q <= lfsr_d;
      rate_q <= rate_d;
    end
  end

  assign stall_s                  = (lfsr_q[2:0] < rate_q);
  assign stall_rate_supported_out = 1'b1;
`else
  logic unused_stall_s;
  assign unused_stall_s           = ^{stall_rate_valid_in, stall_rate_in};
  assign stall_s                  = 1'b0;
  assign stall_rate_supported_out = 1'b0;
`endif

  // Adder pipeline. Stages always advance; valid bits track occupancy.
  always_comb begin
    sum_d = sum_q;
    vld_d = vld_q;
    vld_d[0] = pop_s;
    if (pop_s) begin
      sum_d[0] = cb_a_in + cb_b_in;
    end else begin
      sum_d[0] = sum_q[0];
    end
    for (int i = 1; i < LATENCY; i++) begin
      sum_d[i] = sum_q[i-1];
      vld_d[i] = vld_q[i-1];
    end
  end

  // Result FIFO. The head value is precomputed so the output port is a flop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_s) begin
      mem_d[wr_ptr_q] = sum_q[LATENCY-1];
      wr_ptr_d        = next_ptr(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (xfer_s) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_s, xfer_s})
      2'b10:   buf_cnt_d = buf_cnt_q + CNT_W'(1);
      2'b01:   buf_cnt_d = buf_cnt_q - CNT_W'(1);
      default: buf_cnt_d = buf_cnt_q;
    endcase
    res_valid_d  = (buf_cnt_d != CNT_W'(0));
    res_result_d = mem_d[rd_ptr_d];
  end

  // Credit count: in-flight plus buffered results.
  always_comb begin
    case ({pop_s, xfer_s})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    busy_d = (cnt_d != CNT_W'(0));
  end

  // State registers. Reset drops everything in flight or buffered.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        sum_q[i] <= {WIDTH{1'b0}};
      end
      for (int i = 0; i < OUT_DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      vld_q        <= {LATENCY{1'b0}};
      wr_ptr_q     <= PTR_W'(0);
      rd_ptr_q     <= PTR_W'(0);
      buf_cnt_q    <= CNT_W'(0);
      cnt_q        <= CNT_W'(0);
      busy_q       <= 1'b0;
      res_valid_q  <= 1'b0;
      res_result_q <= {WIDTH{1'b0}};
    end else begin
      sum_q        <= sum_d;
      mem_q        <= mem_d;
      vld_q        <= vld_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      buf_cnt_q    <= buf_cnt_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      res_valid_q  <= res_valid_d;
      res_result_q <= res_result_d;
    end
  end

endmodule
